// File: rtl/ppe_rr_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin arbiter
// and its programmable priority encoder.
package ppe_rr_arbiter_pkg;

    localparam int N                = 1024;
    localparam int LOG2N            = 10;
    localparam int MAX_LOCK_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/ppe_w1024.sv
// Combinational programmable priority encoder: lowest set request at or
// above p_enc, otherwise the lowest set request overall.
module ppe_w1024
    import ppe_rr_arbiter_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [LOG2N-1:0] p_enc,
    output logic [LOG2N-1:0] o_value,
    output logic             valid
);

    logic [LOG2N-1:0] lo_idx;
    logic [LOG2N-1:0] hi_idx;
    logic             hi_found;

    // Scanning downward means the last hit in each region is its lowest index.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = LOG2N'(i);
                if (LOG2N'(i) >= p_enc) begin
                    hi_idx   = LOG2N'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign valid   = |req;
    assign o_value = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/ppe_rr_arbiter.sv
// Registered round-robin arbiter over ppe_w1024 with a valid/ready grant
// handshake, bounded locked bursts and a software-loadable pointer.
module ppe_rr_arbiter
    import ppe_rr_arbiter_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic             lock,
    input  logic             ptr_load,
    input  logic [LOG2N-1:0] ptr_val,
    output logic             gnt_valid,
    output logic [LOG2N-1:0] gnt_idx,
    input  logic             gnt_ready,
    output logic [LOG2N-1:0] ptr
);

    state_t           state;
    logic [7:0]       lock_cnt;
    logic [LOG2N-1:0] next_ptr;
    logic [LOG2N-1:0] p_enc;
    logic [LOG2N-1:0] ppe_value;
    logic             ppe_valid;
    logic             lock_regrant;

    assign next_ptr  = gnt_idx + LOG2N'(1);
    // While a grant is outstanding the encoder only matters on accept, so it
    // can always search from just past the current holder.
    assign p_enc     = (state == GRANT) ? next_ptr : ptr;
    assign gnt_valid = (state == GRANT);

    assign lock_regrant = lock && req[gnt_idx] && en &&
                          (lock_cnt < 8'(MAX_LOCK - 1));

    ppe_w1024 u_ppe (
        .req     (req),
        .p_enc   (p_enc),
        .o_value (ppe_value),
        .valid   (ppe_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            ptr      <= '0;
            lock_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && ppe_valid) begin
                        gnt_idx  <= ppe_value;
                        lock_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (gnt_ready) begin
                        if (lock_regrant) begin
                            lock_cnt <= lock_cnt + 8'd1;
                        end else begin
                            ptr      <= next_ptr;
                            lock_cnt <= '0;
                            if (en && ppe_valid) begin
                                gnt_idx <= ppe_value;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // A software load takes priority over the accept-driven update.
            if (ptr_load) begin
                ptr <= ptr_val;
            end
        end
    end

endmodule

// File: tb/tb_ppe_rr_arbiter.sv
// Self-checking bench: directed scenarios with fixed expectations plus a
// randomized phase compared every cycle against a behavioural model.
module tb_ppe_rr_arbiter;
    import ppe_rr_arbiter_pkg::*;

    localparam int TB_MAX_LOCK = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             en;
    logic             lock;
    logic             ptr_load;
    logic [LOG2N-1:0] ptr_val;
    logic             gnt_valid;
    logic [LOG2N-1:0] gnt_idx;
    logic             gnt_ready;
    logic [LOG2N-1:0] ptr;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    logic             m_valid;
    logic [LOG2N-1:0] m_idx;
    logic [LOG2N-1:0] m_ptr;
    int               m_run;

    ppe_rr_arbiter #(.MAX_LOCK(TB_MAX_LOCK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .en        (en),
        .lock      (lock),
        .ptr_load  (ptr_load),
        .ptr_val   (ptr_val),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_ready (gnt_ready),
        .ptr       (ptr)
    );

    always #5 clk = ~clk;

    // Walk the ring starting at p; the first pending requester wins.
    function automatic logic find_winner(input logic [N-1:0] r, input int p, output int idx);
        idx = 0;
        for (int k = 0; k < N; k++) begin
            int j = (p + k) % N;
            if (r[j]) begin
                idx = j;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        int w;
        logic             nv = m_valid;
        logic [LOG2N-1:0] ni = m_idx;
        logic [LOG2N-1:0] np = m_ptr;
        int               nr = m_run;
        if (!rst_n) begin
            nv = 1'b0; ni = '0; np = '0; nr = 0;
        end else begin
            if (!m_valid) begin
                if (en && find_winner(req, int'(m_ptr), w)) begin
                    nv = 1'b1; ni = LOG2N'(w); nr = 1;
                end
            end else if (gnt_ready) begin
                if (lock && req[m_idx] && en && m_run < TB_MAX_LOCK) begin
                    nr = m_run + 1;
                end else begin
                    np = LOG2N'((int'(m_idx) + 1) % N);
                    if (en && find_winner(req, int'(np), w)) begin
                        ni = LOG2N'(w); nr = 1;
                    end else begin
                        nv = 1'b0; nr = 0;
                    end
                end
            end
            if (ptr_load) np = ptr_val;
        end
        m_valid = nv; m_idx = ni; m_ptr = np; m_run = nr;
    endtask

    task automatic check_val(input string tag, input logic [LOG2N-1:0] obs, input logic [LOG2N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check_bit($sformatf("model_valid@%0d", cycle), gnt_valid, m_valid);
        if (m_valid) check_val($sformatf("model_idx@%0d", cycle), gnt_idx, m_idx);
        check_val($sformatf("model_ptr@%0d", cycle), ptr, m_ptr);
    endtask

    task automatic apply_stimulus();
        checks++;
        assert (!$isunknown(req)) else begin
            errors++;
            $error("[TB] FAIL req_known@%0d: observed=unknown expected=known", cycle);
        end
        model_step();
        @(posedge clk);
        #1;
        cycle++;
        check_output();
    endtask

    task automatic expect_grant(input string tag, input int idx, input int p);
        check_bit({tag, "_valid"}, gnt_valid, 1'b1);
        check_val({tag, "_idx"}, gnt_idx, LOG2N'(idx));
        check_val({tag, "_ptr"}, ptr, LOG2N'(p));
    endtask

    task automatic expect_idle(input string tag, input int p);
        check_bit({tag, "_valid"}, gnt_valid, 1'b0);
        check_val({tag, "_ptr"}, ptr, LOG2N'(p));
    endtask

    initial begin
        int fair_idx [5] = '{3, 7, 1020, 3, 7};
        int fair_ptr [5] = '{0, 4, 8, 1021, 4};
        int cand     [8] = '{0, 1, 2, 5, 6, 511, 1022, 1023};

        rst_n = 1'b0; req = '0; en = 1'b0; lock = 1'b0;
        ptr_load = 1'b0; ptr_val = '0; gnt_ready = 1'b0;
        m_valid = 1'b0; m_idx = '0; m_ptr = '0; m_run = 0;

        // Reset, idle with no requests, then a single request.
        apply_stimulus();
        apply_stimulus();
        expect_idle("reset", 0);
        check_val("reset_idx", gnt_idx, '0);
        rst_n = 1'b1; en = 1'b1;
        apply_stimulus();
        apply_stimulus();
        expect_idle("no_req", 0);
        req[5] = 1'b1;
        apply_stimulus();
        expect_grant("first5", 5, 0);
        gnt_ready = 1'b1; req = '0;
        apply_stimulus();
        expect_idle("after5", 6);

        // Fairness rotation with ready held high.
        gnt_ready = 1'b0; en = 1'b0; ptr_load = 1'b1; ptr_val = '0;
        apply_stimulus();
        ptr_load = 1'b0; en = 1'b1; gnt_ready = 1'b1;
        req[3] = 1'b1; req[7] = 1'b1; req[1020] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus();
            expect_grant($sformatf("fair%0d", i), fair_idx[i], fair_ptr[i]);
        end
        req = '0;
        apply_stimulus();
        expect_idle("fair_end", 8);

        // Pointer wrap from the top of the ring.
        gnt_ready = 1'b0; en = 1'b0; ptr_load = 1'b1; ptr_val = 10'd1022;
        apply_stimulus();
        expect_idle("wrap_load", 1022);
        ptr_load = 1'b0; en = 1'b1; req[1] = 1'b1; req[1023] = 1'b1;
        apply_stimulus();
        expect_grant("wrap_1023", 1023, 1022);
        gnt_ready = 1'b1;
        apply_stimulus();
        expect_grant("wrap_1", 1, 0);
        req = '0;
        apply_stimulus();
        expect_idle("wrap_end", 2);

        // Backpressure: the grant is sticky even after its request drops.
        gnt_ready = 1'b0; req[7] = 1'b1;
        apply_stimulus();
        expect_grant("bp_7", 7, 2);
        req = '0; req[9] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus();
            expect_grant($sformatf("bp_hold%0d", i), 7, 2);
        end
        gnt_ready = 1'b1;
        apply_stimulus();
        expect_grant("bp_9", 9, 8);
        req = '0;
        apply_stimulus();
        expect_idle("bp_end", 10);

        // Locked burst capped at MAX_LOCK grants.
        gnt_ready = 1'b0; lock = 1'b1; req[2] = 1'b1; req[4] = 1'b1;
        apply_stimulus();
        expect_grant("lock_a0", 2, 10);
        gnt_ready = 1'b1;
        apply_stimulus();
        expect_grant("lock_a1", 2, 10);
        apply_stimulus();
        expect_grant("lock_a2", 2, 10);
        apply_stimulus();
        expect_grant("lock_a3", 4, 3);
        req = '0;
        apply_stimulus();
        expect_idle("lock_a_end", 5);

        // Lock ends early when the holder stops requesting.
        gnt_ready = 1'b0; en = 1'b0; ptr_load = 1'b1; ptr_val = '0;
        apply_stimulus();
        ptr_load = 1'b0; en = 1'b1; req[2] = 1'b1; req[4] = 1'b1;
        apply_stimulus();
        expect_grant("lock_b0", 2, 0);
        gnt_ready = 1'b1; req[2] = 1'b0;
        apply_stimulus();
        expect_grant("lock_b1", 4, 3);
        lock = 1'b0; req = '0;
        apply_stimulus();
        expect_idle("lock_b_end", 5);

        // Reset drops an outstanding grant.
        gnt_ready = 1'b0; req[7] = 1'b1;
        apply_stimulus();
        expect_grant("rst_pre", 7, 5);
        rst_n = 1'b0;
        apply_stimulus();
        expect_idle("rst_mid", 0);
        check_val("rst_mid_idx", gnt_idx, '0);
        rst_n = 1'b1;
        apply_stimulus();
        expect_grant("rst_post", 7, 0);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            req = '0;
            foreach (cand[k]) if ($urandom_range(0, 2) == 0) req[cand[k]] = 1'b1;
            rst_n     = ($urandom_range(0, 99) != 0);
            en        = ($urandom_range(0, 9) != 0);
            lock      = $urandom_range(0, 1) == 1;
            gnt_ready = ($urandom_range(0, 2) != 0);
            ptr_load  = ($urandom_range(0, 19) == 0);
            ptr_val   = LOG2N'($urandom_range(0, N - 1));
            apply_stimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ppe_rr_arbiter.md
Name: ppe_rr_arbiter

Overview:
- Registered round-robin arbiter for up to 1024 requesters, built around the existing combinational programmable priority encoder (ppe_w1024).
- Holds a rotating priority pointer and issues one grant at a time over a valid/ready handshake.
- Supports locked bursts with a bounded burst length, and software loading of the pointer.
- Sits between requester queues and a shared downstream resource (egress port or buffer write slot).

Parameters:
- N, 1024, number of requesters; fixed to 1024 to match ppe_w1024.
- LOG2N, 10, index width.
- MAX_LOCK, 8, maximum consecutive grants to one requester under lock; legal range 1..255.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- req  input  N  request vector; bit i = requester i pending
- en  input  1  arbitration enable; 0 = issue no new grants
- lock  input  1  sampled at acceptance; 1 = re-grant the same requester if it still requests
- ptr_load  input  1  load the priority pointer
- ptr_val  input  LOG2N  pointer value for ptr_load
- gnt_valid  output  1  grant outstanding
- gnt_idx  output  LOG2N  granted requester index
- gnt_ready  input  1  consumer accepts the grant
- ptr  output  LOG2N  current priority pointer, for debug/CSR

Behaviour:
- Reset (rst_n=0 at a clk edge) clears everything: gnt_valid=0, gnt_idx=0, ptr=0, lock_cnt=0, state=IDLE.
  - Reset wins over every other input and drops an outstanding grant immediately.
- PPE semantics:
  - Grant goes to the lowest set req index >= P_enc.
  - If no such index exists, it wraps to the lowest set index overall.
  - valid=0 when req==0.
- States: IDLE and GRANT.
- IDLE:
  - gnt_valid=0.
  - PPE P_enc = ptr.
  - If en=1 and the PPE reports valid, register gnt_idx = PPE o_value, move to GRANT, set lock_cnt=0.
  - Latency from req to gnt_valid is 1 cycle.
- GRANT:
  - gnt_valid=1; gnt_idx is stable until accepted.
  - The grant is sticky: deasserting req[gnt_idx] before acceptance does not revoke it.
  - An accept occurs when gnt_valid=1 and gnt_ready=1.
- On accept, with locked re-grant (lock=1 and req[gnt_idx]=1 and lock_cnt < MAX_LOCK-1 and en=1):
  - Stay in GRANT with the same gnt_idx.
  - lock_cnt += 1; ptr is unchanged.
- On accept, otherwise:
  - ptr <= gnt_idx+1 (modulo N, so 1023 wraps to 0); lock_cnt=0.
  - The PPE is driven in the same cycle with P_enc = gnt_idx+1 (mod N).
  - If en=1 and the PPE reports valid, register the new grant and stay in GRANT (back-to-back, no bubble).
  - Otherwise go to IDLE.
  - The just-served requester has the lowest priority. It can be re-granted only if it is the sole requester.
- Starvation bound: with lock held high, a requester receives at most MAX_LOCK consecutive grants. MAX_LOCK=1 disables locking.
- en=0:
  - No new grant is issued.
  - An outstanding grant stays valid until accepted, then the arbiter goes to IDLE.
- ptr_load=1:
  - ptr <= ptr_val on the next edge.
  - It overrides the accept-driven ptr update in the same cycle.
  - It does not change an already-registered gnt_idx.
  - Same-cycle arbitration still uses the pre-load P_enc.
- Unknown or X bits on req are not allowed; the bench asserts this.

Decomposition:
- Shared package contents:
  - N, LOG2N
  - state encoding: IDLE=1'b0, GRANT=1'b1
  - MAX_LOCK default
- Sub-module: ppe_w1024, instantiated unchanged, combinational, one instance.
- P_enc mux, pointer register, lock counter and FSM live in ppe_rr_arbiter; no further sub-modules.

Test Plan:
- Reset, then req=0, en=1 -> gnt_valid stays 0 and ptr=0. Drive req bit 5 -> gnt_valid=1 with gnt_idx=5 on the next cycle.
- Fairness, req={3,7,1020} constant, gnt_ready=1 every cycle -> gnt_idx sequence 3,7,1020,3,7 with no bubbles; ptr after the first accept is 4.
- Wrap: ptr_load with ptr_val=1022, req={1,1023} -> grant 1023, then ptr=0, then grant 1.
- Backpressure: grant to idx 7, gnt_ready=0 for 5 cycles while req[7] drops and req[9] rises -> gnt_idx holds 7 and gnt_valid holds 1. Then gnt_ready=1 -> next grant is 9.
- Lock, MAX_LOCK=3, lock=1, req={2,4} -> grants 2,2,2,4. Lock with req[2] dropped after the first accept -> grants 2,4.
- Reset mid-grant: gnt_valid=1 with gnt_idx=7, assert rst_n=0 for one edge -> gnt_valid=0, gnt_idx=0, ptr=0. After release with req={7} -> grant 7 after 1 cycle.
